// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver. Takes the asynchronous serial line, passes it
//   through a two-flop synchroniser and recovers frames using a 3-sample
//   majority vote around the centre of every bit. Start bits that do not hold
//   low at the centre are treated as glitches and dropped. Parity, framing and
//   break conditions are reported with each completed frame.
//
// Parameters
//   DBIT        data bits per frame (5..9), LSB first
//   OVERSAMPLE  s_tick pulses per bit time (even, >= 8)
//   SB_TICK     s_tick pulses of stop time (>= OVERSAMPLE)
//   PARITY_EN   1 = a parity bit follows the data bits
//   PARITY_ODD  1 = odd parity, 0 = even parity
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   rx            serial input, asynchronous, idle high
//   s_tick        oversample enable, one clk wide
//   rx_done_tick  one-clk pulse when a frame completes
//   dout          received data, held until the next rx_done_tick
//   parity_err    parity mismatch on the last frame
//   frame_err     stop bit sampled low on the last frame
//   break_det     last frame was all zeros including stop (line break)
//   busy          receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            busy
);

    localparam int SW = $clog2(SB_TICK);
    localparam int NW = $clog2(DBIT);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] S_V0        = SW'(M - 1);
    localparam logic [SW-1:0] S_V1        = SW'(M);
    localparam logic [SW-1:0] S_V2        = SW'(M + 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
    localparam logic          PAR_EN      = (PARITY_EN != 0);
    localparam logic          PAR_ODD     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    // Two-of-three majority of the centre samples.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    logic            rx_sync_p0;
    logic            rx_sync_p1;
    logic            rx_s;

    state_t          state, state_nx;
    logic [SW-1:0]   s_cnt, s_nx;
    logic [NW-1:0]   n_cnt, n_nx;
    logic [DBIT-1:0] shreg, shreg_nx;
    logic            par_bit, par_bit_nx;
    logic [2:0]      smp, smp_nx;
    logic            vote;
    logic            in_frame;

    logic            done_nx;
    logic [DBIT-1:0] dout_nx;
    logic            perr_nx;
    logic            ferr_nx;
    logic            brk_nx;

    assign rx_s = rx_sync_p1;
    assign vote = maj3(smp);
    assign busy = (state != IDLE);
    assign in_frame = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

    // Stage p0/p1: line synchroniser, resets to the idle (high) level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    // Frame state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            smp          <= '0;
            rx_done_tick <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            state        <= state_nx;
            s_cnt        <= s_nx;
            n_cnt        <= n_nx;
            shreg        <= shreg_nx;
            par_bit      <= par_bit_nx;
            smp          <= smp_nx;
            rx_done_tick <= done_nx;
            dout         <= dout_nx;
            parity_err   <= perr_nx;
            frame_err    <= ferr_nx;
            break_det    <= brk_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        s_nx       = s_cnt;
        n_nx       = n_cnt;
        shreg_nx   = shreg;
        par_bit_nx = par_bit;
        smp_nx     = smp;
        done_nx    = 1'b0;
        dout_nx    = dout;
        perr_nx    = parity_err;
        ferr_nx    = frame_err;
        brk_nx     = break_det;

        // Centre samples; in STOP the counter runs past OVERSAMPLE, so only
        // the first stop bit is voted on.
        if (s_tick && in_frame) begin
            if (s_cnt == S_V0) smp_nx[0] = rx_s;
            if (s_cnt == S_V1) smp_nx[1] = rx_s;
            if (s_cnt == S_V2) smp_nx[2] = rx_s;
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt == S_BIT_LAST) begin
                        s_nx     = '0;
                        n_nx     = '0;
                        // A start bit that is high at its centre was a glitch.
                        state_nx = vote ? IDLE : DATA;
                    end else begin
                        s_nx = s_cnt + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt == S_BIT_LAST) begin
                        s_nx     = '0;
                        shreg_nx = {vote, shreg[DBIT-1:1]};
                        if (n_cnt == N_LAST) begin
                            state_nx = PAR_EN ? PARITY : STOP;
                        end else begin
                            n_nx = n_cnt + NW'(1);
                        end
                    end else begin
                        s_nx = s_cnt + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt == S_BIT_LAST) begin
                        s_nx       = '0;
                        par_bit_nx = vote;
                        state_nx   = STOP;
                    end else begin
                        s_nx = s_cnt + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt == S_STOP_LAST) begin
                        s_nx    = '0;
                        done_nx = 1'b1;
                        dout_nx = shreg;
                        perr_nx = PAR_EN & (^shreg ^ par_bit ^ PAR_ODD);
                        ferr_nx = ~vote;
                        brk_nx  = ~vote & (shreg == '0) & (~PAR_EN | ~par_bit);
                        // A low stop bit means the line may still be held
                        // low; wait for it to rise before hunting a new start.
                        state_nx = vote ? IDLE : WAIT_HIGH;
                    end else begin
                        s_nx = s_cnt + SW'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

    localparam int TCLK = 4;   // clk cycles per s_tick
    localparam int OS   = 16;  // s_tick per bit in every instance

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic s_tick = 1'b0;
    int   tick_cnt = 0;

    always @(posedge clk) begin
        tick_cnt <= (tick_cnt == TCLK - 1) ? 0 : tick_cnt + 1;
        s_tick   <= (tick_cnt == TCLK - 1);
    end

    logic [2:0] rx_line = 3'b111;
    logic [2:0] done_v, pe_v, fe_v, bk_v, busy_v;
    logic [7:0] dout_def, dout_par;
    logic [6:0] dout_d7;
    logic [8:0] dout_a [3];

    assign dout_a[0] = {1'b0, dout_def};
    assign dout_a[1] = {1'b0, dout_par};
    assign dout_a[2] = {2'b00, dout_d7};

    uart_rx_param u_def (
        .clk(clk), .reset_n(rst_n), .rx(rx_line[0]), .s_tick(s_tick),
        .rx_done_tick(done_v[0]), .dout(dout_def), .parity_err(pe_v[0]),
        .frame_err(fe_v[0]), .break_det(bk_v[0]), .busy(busy_v[0])
    );

    uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .reset_n(rst_n), .rx(rx_line[1]), .s_tick(s_tick),
        .rx_done_tick(done_v[1]), .dout(dout_par), .parity_err(pe_v[1]),
        .frame_err(fe_v[1]), .break_det(bk_v[1]), .busy(busy_v[1])
    );

    uart_rx_param #(.DBIT(7), .SB_TICK(32)) u_d7 (
        .clk(clk), .reset_n(rst_n), .rx(rx_line[2]), .s_tick(s_tick),
        .rx_done_tick(done_v[2]), .dout(dout_d7), .parity_err(pe_v[2]),
        .frame_err(fe_v[2]), .break_det(bk_v[2]), .busy(busy_v[2])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         id;
        int         num;
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    exp_t sb_q[$];
    int   frame_num = 0;
    int   done_cnt [3] = '{0, 0, 0};
    exp_t e;

    task automatic push_exp(input int id, input logic [8:0] d,
                            input logic pe, input logic fe, input logic bk);
        exp_t x;
        x.id = id; x.num = frame_num; x.d = d; x.pe = pe; x.fe = fe; x.bk = bk;
        frame_num++;
        sb_q.push_back(x);
    endtask

    // Scoreboard: every rx_done_tick pops one expected frame.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) begin
                done_cnt[i]++;
                if (sb_q.size() == 0) begin
                    chk($sformatf("spurious_done_dut%0d", i), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("f%0d_dut_id", e.num), 32'(i), 32'(e.id));
                    chk($sformatf("f%0d_dout", e.num), 32'(dout_a[i]), 32'(e.d));
                    chk($sformatf("f%0d_parity_err", e.num), 32'(pe_v[i]), 32'(e.pe));
                    chk($sformatf("f%0d_frame_err", e.num), 32'(fe_v[i]), 32'(e.fe));
                    chk($sformatf("f%0d_break_det", e.num), 32'(bk_v[i]), 32'(e.bk));
                end
            end
        end
    end

    task automatic drive_bit(input int which, input logic v, input int nticks);
        rx_line[which] = v;
        repeat (nticks * TCLK) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nd,
                              input bit par_en, input logic par, input logic stop_val,
                              input int stop_ticks, input int glitch_bit);
        drive_bit(which, 1'b0, OS);
        for (int k = 0; k < nd; k++) begin
            if (k == glitch_bit) begin
                drive_bit(which, data[k], OS / 2);
                drive_bit(which, ~data[k], 1);
                drive_bit(which, data[k], OS / 2 - 1);
            end else begin
                drive_bit(which, data[k], OS);
            end
        end
        if (par_en) drive_bit(which, par, OS);
        drive_bit(which, stop_val, stop_ticks);
    endtask

    int base;

    initial begin
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_dout_dut%0d", i), 32'(dout_a[i]), 32'd0);
            chk($sformatf("rst_busy_dut%0d", i), 32'(busy_v[i]), 32'd0);
            chk($sformatf("rst_done_dut%0d", i), 32'(done_v[i]), 32'd0);
            chk($sformatf("rst_flags_dut%0d", i), 32'({pe_v[i], fe_v[i], bk_v[i]}), 32'd0);
        end
        rst_n = 1'b1;
        drive_bit(0, 1'b1, 2 * OS);

        // Clean 0x55 frame, one stop bit
        push_exp(0, 9'h055, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b1, OS, -1);
        drive_bit(0, 1'b1, 2 * OS);
        chk("t55_done_cnt", 32'(done_cnt[0]), 32'd1);
        chk("t55_busy_idle", 32'(busy_v[0]), 32'd0);

        // Start glitch: low for 6 ticks only
        base = done_cnt[0];
        drive_bit(0, 1'b0, 6);
        drive_bit(0, 1'b1, 3);
        chk("glitch_busy_start", 32'(busy_v[0]), 32'd1);
        drive_bit(0, 1'b1, 24);
        chk("glitch_busy_drop", 32'(busy_v[0]), 32'd0);
        chk("glitch_no_done", 32'(done_cnt[0]), 32'(base));

        // 0x3C with low stop bit, line held low afterwards
        push_exp(0, 9'h03C, 1'b0, 1'b1, 1'b0);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, OS, -1);
        drive_bit(0, 1'b0, 2 * OS);
        chk("ferr_done_cnt", 32'(done_cnt[0]), 32'(base + 1));
        chk("ferr_wait_high_busy", 32'(busy_v[0]), 32'd1);
        drive_bit(0, 1'b1, 4);
        chk("ferr_busy_released", 32'(busy_v[0]), 32'd0);
        drive_bit(0, 1'b1, OS);

        // Break: line low for three frame times
        base = done_cnt[0];
        push_exp(0, 9'h000, 1'b0, 1'b1, 1'b1);
        drive_bit(0, 1'b0, 30 * OS);
        chk("break_busy_low_line", 32'(busy_v[0]), 32'd1);
        drive_bit(0, 1'b1, 2 * OS);
        chk("break_single_done", 32'(done_cnt[0]), 32'(base + 1));
        chk("break_busy_idle", 32'(busy_v[0]), 32'd0);

        // Even parity instance
        base = done_cnt[1];
        push_exp(1, 9'h0A3, 1'b0, 1'b0, 1'b0);
        send_frame(1, 9'h0A3, 8, 1'b1, 1'b0, 1'b1, OS, -1);
        drive_bit(1, 1'b1, 2 * OS);
        push_exp(1, 9'h0A3, 1'b1, 1'b0, 1'b0);
        send_frame(1, 9'h0A3, 8, 1'b1, 1'b1, 1'b1, OS, -1);
        drive_bit(1, 1'b1, 2 * OS);
        push_exp(1, 9'h007, 1'b0, 1'b0, 1'b0);
        send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1'b1, OS, -1);
        drive_bit(1, 1'b1, 2 * OS);
        chk("par_done_cnt", 32'(done_cnt[1]), 32'(base + 3));

        // DBIT=7, two stop bits, single-tick glitch inside data bit 3
        base = done_cnt[2];
        push_exp(2, 9'h02A, 1'b0, 1'b0, 1'b0);
        send_frame(2, 9'h02A, 7, 1'b0, 1'b0, 1'b1, 2 * OS, 3);
        drive_bit(2, 1'b1, 2 * OS);
        chk("d7_done_cnt", 32'(done_cnt[2]), 32'(base + 1));

        // Reset in the middle of a frame
        base = done_cnt[2];
        drive_bit(2, 1'b0, OS);
        drive_bit(2, 1'b1, OS);
        drive_bit(2, 1'b0, OS / 2);
        chk("midrst_busy_before", 32'(busy_v[2]), 32'd1);
        rx_line[2] = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_dout", 32'(dout_a[2]), 32'd0);
        chk("midrst_busy", 32'(busy_v[2]), 32'd0);
        chk("midrst_flags", 32'({pe_v[2], fe_v[2], bk_v[2]}), 32'd0);
        drive_bit(2, 1'b1, 3 * OS);
        chk("midrst_no_done", 32'(done_cnt[2]), 32'(base));

        push_exp(2, 9'h041, 1'b0, 1'b0, 1'b0);
        send_frame(2, 9'h041, 7, 1'b0, 1'b0, 1'b1, 2 * OS, -1);
        drive_bit(2, 1'b1, 2 * OS);
        chk("d7_after_rst_done", 32'(done_cnt[2]), 32'(base + 1));

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
